// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Brief    : 640x480@60 VGA raster timing: pixel counters, sync, blank, strobes
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       line_start
);

    localparam logic [9:0] C_H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] C_V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] C_H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] C_HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] C_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] C_VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] C_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_hc;
    logic [9:0] r_vc;

    // Outputs decode the pre-increment counters, so they trail r_hc/r_vc by one edge.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc        <= 10'd0;
            r_vc        <= 10'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (pix_en) begin
            if (r_hc == C_H_LAST) begin
                r_hc <= 10'd0;
                r_vc <= (r_vc == C_V_LAST) ? 10'd0 : r_vc + 10'd1;
            end else begin
                r_hc <= r_hc + 10'd1;
            end
            DrawX       <= r_hc;
            DrawY       <= r_vc;
            hs          <= !((r_hc >= C_HS_START) && (r_hc < C_HS_END));
            vs          <= !((r_vc >= C_VS_START) && (r_vc < C_VS_END));
            blank       <= (r_hc < C_H_ACT) && (r_vc < C_V_ACT);
            line_start  <= (r_hc == 10'd0);
            frame_start <= (r_hc == 10'd0) && (r_vc == 10'd0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench for vga_timing_gen (full-size and reduced raster)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    logic pix_en  = 1'b0;

    always #5 vga_clk = ~vga_clk;

    logic       f_hs, f_vs, f_blank, f_fs, f_ls;
    logic [9:0] f_x, f_y;
    logic       s_hs, s_vs, s_blank, s_fs, s_ls;
    logic [9:0] s_x, s_y;

    vga_timing_gen dut_full (
        .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
        .hs(f_hs), .vs(f_vs), .blank(f_blank), .DrawX(f_x), .DrawY(f_y),
        .frame_start(f_fs), .line_start(f_ls)
    );

    // Reduced raster so whole frames fit in a short run: 32 x 19 = 608 pixels/frame.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_small (
        .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
        .hs(s_hs), .vs(s_vs), .blank(s_blank), .DrawX(s_x), .DrawY(s_y),
        .frame_start(s_fs), .line_start(s_ls)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int edges  = 0;   // enabled, non-reset edges since the last reset

    // Reference: after k enabled edges the outputs describe raster pixel k-1
    // (modulo the frame size); before any, they show the reset values.
    function automatic logic [24:0] model(input int k,
                                          input int ha, input int hf, input int hsy, input int hb,
                                          input int va, input int vf, input int vsy, input int vb);
        int ht, vt, p, x, y;
        logic e_hs, e_vs, e_bl, e_fs, e_ls;
        if (k == 0) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
        ht   = ha + hf + hsy + hb;
        vt   = va + vf + vsy + vb;
        p    = (k - 1) % (ht * vt);
        x    = p % ht;
        y    = p / ht;
        e_hs = !(x >= ha + hf && x < ha + hf + hsy);
        e_vs = !(y >= va + vf && y < va + vf + vsy);
        e_bl = (x < ha) && (y < va);
        e_ls = (x == 0);
        e_fs = (x == 0) && (y == 0);
        return {e_hs, e_vs, e_bl, e_fs, e_ls, 10'(x), 10'(y)};
    endfunction

    task automatic check_all();
        logic [24:0] ef, es;
        ef = model(edges, 640, 16, 96, 48, 480, 10, 2, 33);
        es = model(edges, 16, 4, 6, 6, 12, 2, 2, 3);
        n_cmp++;
        assert ({f_hs, f_vs, f_blank, f_fs, f_ls} === ef[24:20]) else begin
            n_fail++;
            $error("FAIL full_flags(hs,vs,blank,fs,ls) obs=%b exp=%b edges=%0d",
                   {f_hs, f_vs, f_blank, f_fs, f_ls}, ef[24:20], edges);
        end
        n_cmp++;
        assert ({f_x, f_y} === ef[19:0]) else begin
            n_fail++;
            $error("FAIL full_xy obs=(%0d,%0d) exp=(%0d,%0d) edges=%0d",
                   f_x, f_y, ef[19:10], ef[9:0], edges);
        end
        n_cmp++;
        assert ({s_hs, s_vs, s_blank, s_fs, s_ls} === es[24:20]) else begin
            n_fail++;
            $error("FAIL small_flags(hs,vs,blank,fs,ls) obs=%b exp=%b edges=%0d",
                   {s_hs, s_vs, s_blank, s_fs, s_ls}, es[24:20], edges);
        end
        n_cmp++;
        assert ({s_x, s_y} === es[19:0]) else begin
            n_fail++;
            $error("FAIL small_xy obs=(%0d,%0d) exp=(%0d,%0d) edges=%0d",
                   s_x, s_y, es[19:10], es[9:0], edges);
        end
    endtask

    task automatic step(input logic r, input logic en);
        reset  = r;
        pix_en = en;
        @(posedge vga_clk);
        if (r)       edges = 0;
        else if (en) edges++;
        #1;
        check_all();
    endtask

    initial begin
        int hs_low, ls_cnt, bl_cnt, fs_cnt, vs_low, last_fs;

        // Reset held with pix_en=1: reset must win and everything stays at reset values.
        #1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

        // Free run 15200 cycles: 19 full-size lines, 25 reduced frames.
        hs_low = 0; ls_cnt = 0; bl_cnt = 0; fs_cnt = 0; vs_low = 0; last_fs = -1;
        for (int i = 0; i < 15200; i++) begin
            step(1'b0, 1'b1);
            hs_low += (f_hs == 1'b0) ? 1 : 0;
            ls_cnt += f_ls ? 1 : 0;
            bl_cnt += s_blank ? 1 : 0;
            vs_low += (s_vs == 1'b0) ? 1 : 0;
            if (s_fs) begin
                fs_cnt++;
                if (last_fs >= 0) begin
                    n_cmp++;
                    assert (i - last_fs === 608) else begin
                        n_fail++;
                        $error("FAIL small_frame_spacing obs=%0d exp=608", i - last_fs);
                    end
                end
                last_fs = i;
            end
        end
        n_cmp++;
        assert (hs_low === 19 * 96) else begin
            n_fail++; $error("FAIL full_hs_low_count obs=%0d exp=%0d", hs_low, 19 * 96);
        end
        n_cmp++;
        assert (ls_cnt === 19) else begin
            n_fail++; $error("FAIL full_line_start_count obs=%0d exp=19", ls_cnt);
        end
        n_cmp++;
        assert (bl_cnt === 25 * 16 * 12) else begin
            n_fail++; $error("FAIL small_blank_count obs=%0d exp=%0d", bl_cnt, 25 * 16 * 12);
        end
        n_cmp++;
        assert (vs_low === 25 * 2 * 32) else begin
            n_fail++; $error("FAIL small_vs_low_count obs=%0d exp=%0d", vs_low, 25 * 2 * 32);
        end
        n_cmp++;
        assert (fs_cnt === 25) else begin
            n_fail++; $error("FAIL small_frame_start_count obs=%0d exp=25", fs_cnt);
        end

        // Alternating, then random pix_en: stalls must freeze counters and outputs.
        for (int i = 0; i < 2000; i++) step(1'b0, 1'(i % 2));
        for (int i = 0; i < 3000; i++) step(1'b0, 1'($urandom_range(0, 1)));

        // Mid-line reset at DrawX=300 of the full-size raster.
        for (int k = 0; k < 1000 && f_x != 10'd300; k++) step(1'b0, 1'b1);
        n_cmp++;
        assert (f_x === 10'd300) else begin
            n_fail++; $error("FAIL reach_x300_timeout obs=%0d exp=300", f_x);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) step(1'b0, 1'b1);

        // Random pix_en with rare resets, some of them coinciding with pix_en=1.
        for (int i = 0; i < 20000; i++)
            step(1'(($urandom % 300) == 0), 1'($urandom_range(0, 3) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing for the renderer stage that consumes DrawX/DrawY/blank and drives RGB.
- Maintains free-running horizontal and vertical pixel counters.
- Outputs registered hs/vs sync, active-high blank (1 = visible pixel), the current pixel coordinates, and frame/line strobes for game logic.
- Sits directly upstream of the sprite/palette renderer and shares its vga_clk.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- vga_clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel advance enable; when 0, counters and all outputs hold
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank  out  1  1 = visible region, 0 = blanking
- DrawX  out  10  current pixel column
- DrawY  out  10  current pixel row
- frame_start  out  1  one-cycle strobe at pixel (0,0)
- line_start  out  1  one-cycle strobe at column 0 of every line

Behaviour:
- Periods:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
  - Counters hc and vc are 10 bits each.
- Counter update on an edge with reset=0 and pix_en=1:
  - If hc==H_TOTAL-1: hc<=0, and vc<=(vc==V_TOTAL-1)?0:vc+1.
  - Otherwise hc<=hc+1 and vc holds.
- Output decode, each registered from the current (hc,vc) on the same enabled edge, so outputs lag the counters by exactly one cycle:
  - DrawX<=hc and DrawY<=vc, over the full ranges 0..799 and 0..524; values are not clamped during blanking.
  - hs<=0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, i.e. hc 656..751.
  - vs<=0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, i.e. vc 490..491. vs changes only with hc, so it switches aligned to column 0.
  - blank<=1 iff hc<H_ACTIVE && vc<V_ACTIVE.
  - line_start<=(hc==0).
  - frame_start<=(hc==0 && vc==0).
- Reset (synchronous; also applies mid-frame): hc=0, vc=0, hs=1, vs=1, blank=0, DrawX=0, DrawY=0, frame_start=0, line_start=0.
- First enabled edge after reset deasserts: outputs present pixel (0,0) with blank=1, line_start=1, frame_start=1, while the counters move to (1,0).
- pix_en=0: counters and every output register hold their values. Strobes are not re-generated; if a strobe was 1 it stays 1 for the stalled cycles. Consumers must qualify strobes with pix_en.
- reset has priority over pix_en.
- Every output is driven from a flop; there are no combinational paths from inputs to outputs.
- Sustained pix_en=1: one frame = 420000 cycles.
  - hs low for 96 cycles per line.
  - vs low for 1600 cycles per frame.
  - blank high for 640 cycles on each of lines 0..479 (307200 cycles per frame).

Test Plan:
- Reset held 5 cycles, then pix_en=1 -> during reset hs=1, vs=1, blank=0, DrawX=0, DrawY=0; cycle 1 after release: DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1; cycle 2: DrawX=1, strobes=0.
- Free run one line -> blank falls when DrawX=640; hs falls at DrawX=656 and rises at DrawX=752; line_start recurs exactly 800 cycles later with DrawX=0, DrawY=1.
- Free run two frames -> frame_start spaced exactly 420000 cycles apart; vs=0 only while DrawY is 490 or 491 (1600 cycles); DrawY wraps 524->0 with DrawX 799->0; total blank=1 count 307200 per frame.
- pix_en toggled 1/0 every cycle for 2000 cycles -> outputs advance only on enabled edges; DrawX sequence is identical to the free-run sequence sampled on pix_en=1; hold cycles show unchanged values.
- reset asserted for 1 cycle at DrawX=300, DrawY=200 -> next cycle all outputs at reset values; the frame restarts from (0,0) with frame_start on the first enabled edge.
- reset and pix_en both 1 -> reset wins; counters stay at 0.
